// File: rtl/pe_pkg.sv
// pe_pkg: shared types and limits for the PE row scheduler slice.
package pe_pkg;
   localparam int KMAX = 15;
   localparam int K_W = 8;
   localparam int DIM_W = 8;
   typedef enum logic [2:0] {IDLE, START, FEED, COLLECT, OUT, DONE} sched_state_t;
   typedef struct packed {
      logic [K_W-1:0]   kernel_size;
      logic [DIM_W-1:0] ofmap_w;
      logic [DIM_W-1:0] ofmap_h;
   } tile_cfg_t;
   function automatic logic cfg_legal(tile_cfg_t c);
      return c.kernel_size != '0 && c.kernel_size <= K_W'(KMAX) && c.ofmap_w != '0 && c.ofmap_h != '0;
   endfunction
endpackage

// File: rtl/pe_row_scheduler_if.sv
// pe_row_scheduler_if: config, PE-row, activation and writer signals of the scheduler.
interface pe_row_scheduler_if #(
   parameter int NUM_PE = 4,
   parameter int DIM_W = pe_pkg::DIM_W,
   parameter int K_W = pe_pkg::K_W
);
   logic              cfg_valid, cfg_ready, cfg_err;
   logic [K_W-1:0]    cfg_kernel_size;
   logic [DIM_W-1:0]  cfg_ofmap_w, cfg_ofmap_h;
   logic              pe_start, act_valid;
   logic [K_W-1:0]    act_kx, act_ky;
   logic [DIM_W-1:0]  act_ox, act_oy;
   logic [NUM_PE-1:0] pe_opsum_valid;
   logic              out_valid, out_ready;
   logic [DIM_W-1:0]  out_ox, out_oy;
   logic              busy, done;
   modport master (
      input  cfg_valid, cfg_kernel_size, cfg_ofmap_w, cfg_ofmap_h, pe_opsum_valid, out_ready,
      output cfg_ready, cfg_err, pe_start, act_valid, act_kx, act_ky, act_ox, act_oy,
             out_valid, out_ox, out_oy, busy, done
   );
   modport slave (
      output cfg_valid, cfg_kernel_size, cfg_ofmap_w, cfg_ofmap_h, pe_opsum_valid, out_ready,
      input  cfg_ready, cfg_err, pe_start, act_valid, act_kx, act_ky, act_ox, act_oy,
             out_valid, out_ox, out_oy, busy, done
   );
endinterface

// File: rtl/pe_row_scheduler_window_addr_gen.sv
// window_addr_gen: tap (kx,ky) and window-origin (ox,oy) raster counters.
module window_addr_gen #(
   parameter int K_W = 8,
   parameter int DIM_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clear,
   input  logic             step_tap,
   input  logic             step_win,
   input  logic [K_W-1:0]   k_last,
   input  logic [DIM_W-1:0] w_last,
   input  logic [DIM_W-1:0] h_last,
   output logic [K_W-1:0]   kx,
   output logic [K_W-1:0]   ky,
   output logic [DIM_W-1:0] ox,
   output logic [DIM_W-1:0] oy,
   output logic             last_tap,
   output logic             last_win
);
   assign last_tap = kx == k_last && ky == k_last;
   assign last_win = ox == w_last && oy == h_last;
   // the last tap wraps both tap counters, so each window starts from (0,0)
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) {kx, ky, ox, oy} <= '0;
      else if (clear) {kx, ky, ox, oy} <= '0;
      else begin
         if (step_tap) begin
            kx <= kx == k_last ? '0 : kx + 1'b1;
            ky <= kx != k_last ? ky : ky == k_last ? '0 : ky + 1'b1;
         end
         if (step_win) begin
            ox <= ox == w_last ? '0 : ox + 1'b1;
            oy <= ox == w_last ? oy + 1'b1 : oy;
         end
      end
endmodule

// File: rtl/pe_row_scheduler.sv
// pe_row_scheduler: walks one PE row through every window of an ofmap tile,
// feeding K*K taps per window and handing each result to the ofmap writer.
module pe_row_scheduler #(
   parameter int NUM_PE = 4,
   parameter int DIM_W = pe_pkg::DIM_W,
   parameter int K_W = pe_pkg::K_W
) (
   input logic clk,
   input logic rstn,
   pe_row_scheduler_if.master bus
);
   import pe_pkg::*;
   sched_state_t state, state_nx;
   tile_cfg_t cfg, cfg_in;
   logic [NUM_PE-1:0] mask, mask_nx;
   logic cfg_ok, last_tap, last_win, step_tap, step_win, clear;
   logic [K_W-1:0] kx, ky;
   logic [DIM_W-1:0] ox, oy;
   assign cfg_in = {bus.cfg_kernel_size, bus.cfg_ofmap_w, bus.cfg_ofmap_h};
   assign cfg_ok = cfg_legal(cfg_in);
   assign mask_nx = mask | bus.pe_opsum_valid;
   window_addr_gen #(.K_W(K_W), .DIM_W(DIM_W)) u_addr (
      .clk(clk), .rstn(rstn), .clear(clear), .step_tap(step_tap), .step_win(step_win),
      .k_last(cfg.kernel_size - 1'b1), .w_last(cfg.ofmap_w - 1'b1), .h_last(cfg.ofmap_h - 1'b1),
      .kx(kx), .ky(ky), .ox(ox), .oy(oy), .last_tap(last_tap), .last_win(last_win)
   );
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.cfg_valid && cfg_ok) state_nx = START;
         START:   state_nx = FEED;
         FEED:    if (last_tap) state_nx = COLLECT;
         COLLECT: if (&mask_nx) state_nx = OUT;
         OUT:     if (bus.out_ready) state_nx = last_win ? DONE : START;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // psum-done pulses are gathered from the first tap on, so early PEs are not lost
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         cfg <= '0;
         mask <= '0;
      end else begin
         if (clear) cfg <= cfg_in;
         mask <= state == START ? '0 : (state == FEED || state == COLLECT) ? mask_nx : mask;
      end
   always_comb begin
      clear = state == IDLE && bus.cfg_valid && cfg_ok;
      step_tap = state == FEED;
      step_win = state == OUT && bus.out_ready && !last_win;
      bus.cfg_ready = state == IDLE;
      bus.cfg_err = state == IDLE && bus.cfg_valid && !cfg_ok;
      bus.pe_start = state == START;
      bus.act_valid = state == FEED;
      bus.act_kx = kx;
      bus.act_ky = ky;
      bus.act_ox = ox;
      bus.act_oy = oy;
      bus.out_valid = state == OUT;
      bus.out_ox = ox;
      bus.out_oy = oy;
      bus.busy = state != IDLE;
      bus.done = state == DONE;
   end
endmodule
